restoring_divider: RTL and testbench
====================================

# restoring_divider

Sequential unsigned divider that is the inverse counterpart of the team's Booth multiplier. It divides a 10-bit dividend by a 5-bit divisor using the restoring algorithm, one quotient bit per clock. It uses the same 5-bit serial word protocol as the multiplier (start, data_in, data_out, done), so it drops into the same host harness. It returns a 10-bit quotient and a 5-bit remainder.

## Interface
- No parameters; widths fixed (dividend 10, divisor 5, bus 5).
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  operation request; level, may be held high for several cycles.
- data_in  input  5  serial operand words: dividend[9:5], dividend[4:0], divisor.
- done  output  1  high for exactly one cycle, marking the first result word.
- data_out  output  5  serial result words: quotient[9:5], quotient[4:0], remainder.
- err  output  1  divide-by-zero flag; present only with DIVZERO_CHK_EN.

## Operation
- States: IDLE, START, LD_HI, LD_LO, LD_DV, CALC, OUT_QH, OUT_QL, OUT_REM.
- IDLE: start=1 → START; otherwise stay.
- START: stay while start=1; start=0 → LD_HI. Holding start is therefore harmless.
- LD_HI captures data_in into dividend[9:5] → LD_LO.
- LD_LO captures dividend[4:0] → LD_DV.
- LD_DV captures the divisor, clears R (6-bit partial remainder) and the 4-bit counter → CALC.
- CALC, per cycle, MSB of dividend first:
  - R' = {R[4:0], next dividend bit}.
  - If R' ≥ divisor: R = R' − divisor, qbit = 1; else R = R', qbit = 0.
  - qbit shifts into quotient LSB. R' never exceeds 63.
  - Counter increments; after 10 CALC cycles → OUT_QH.
- OUT_QH: data_out = quotient[9:5], done = 1 → OUT_QL.
- OUT_QL: data_out = quotient[4:0] → OUT_REM.
- OUT_REM: data_out = R[4:0] → IDLE.
- data_out = 0 and done = 0 in every other state.
- start is ignored outside IDLE and START.
- Divisor 0 without the check: every step subtracts; result is quotient 10'h3FF, remainder dividend[4:0]. Deterministic; the bench relies on it.

## Timing
- Reset: state IDLE; done = 0, data_out = 0, err = 0; quotient, R, counter, operand registers all 0.
- Reset asserted in any state, including mid-CALC or mid-output, aborts at the next edge. Partial results are discarded and no done pulse is issued.
- data_in is sampled on the edge leaving LD_HI, LD_LO and LD_DV, i.e. the 1st, 2nd and 3rd cycles after start is seen low.
- Latency: OUT_QH is entered 13 cycles after LD_HI (3 load + 10 calc).
- Results occupy three consecutive cycles: OUT_QH, OUT_QL, OUT_REM.
- Back-to-back operation: start may rise in the cycle after OUT_REM (IDLE).
- Outputs are registered as a decode of the state register; no combinational path from inputs to outputs.

## Configuration
- DIVZERO_CHK_EN defined:
  - err port exists.
  - In LD_DV, if data_in = 0, transition directly to OUT_QH. CALC is skipped and latency drops to 3 cycles.
  - Quotient is forced to 10'h3FF and R to dividend[4:0].
  - err = 1 during OUT_QH through OUT_REM, 0 elsewhere.
- DIVZERO_CHK_EN undefined:
  - No err port.
  - Divisor 0 runs the full 10 CALC cycles and yields the same quotient and remainder values.

## Test plan
- 1000/7: words 31, 8, 7 → after 13 cycles data_out 4, 14, 6 (q=142, r=6); done high only with word 4.
- 1023/1 → 31, 31, 0. 17/31 (words 0, 17, 31) → 0, 0, 17.
- start held high 3 cycles, then low → loading begins the cycle after start falls; same results as the single-cycle start case.
- 545/0 (words 17, 1, 0) → 31, 31, 1.
  - With DIVZERO_CHK_EN: OUT_QH reached 3 cycles after LD_HI, err = 1.
  - Without: reached after 13 cycles.
- rst pulsed during the 5th CALC cycle → next cycle IDLE, outputs 0, no done. A new 1000/7 then completes correctly.
- start pulsed during CALC → ignored, result unchanged, returns to IDLE after OUT_REM.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 10-bit dividend / 5-bit divisor, one quotient bit
// per clock, using the 5-bit serial word protocol (start, data_in, data_out, done).
// Optional divide-by-zero short-cut and err flag enabled by defining DIVZERO_CHK_EN.
module restoring_divider (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] data_in_i,
  output logic       done_o,
  output logic [4:0] data_out_o
`ifdef DIVZERO_CHK_EN
  ,
  output logic       err_o
`endif
);

  typedef enum logic [3:0] {
    StIdle, StStart, StLdHi, StLdLo, StLdDv, StCalc, StOutQh, StOutQl, StOutRem
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  dvd_q, dvd_d;    // dividend, shifted left MSB-first during CALC
  logic [4:0]  dvs_q, dvs_d;
  logic [9:0]  quot_q, quot_d;
  // After each step R < divisor <= 31, so 5 stored bits hold the partial remainder exactly.
  logic [4:0]  r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  r_prime;
  logic [4:0]  r_sub;
  logic        r_ge;
`ifdef DIVZERO_CHK_EN
  logic        divz_q, divz_d;
`endif

  assign r_prime = {r_q, dvd_q[9]};
  assign r_ge    = (r_prime >= {1'b0, dvs_q});
  // True difference is < 32 whenever r_ge holds, so 5-bit arithmetic is exact.
  assign r_sub   = r_prime[4:0] - dvs_q;

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StStart;
      StStart:  if (!start_i) state_d = StLdHi;
      StLdHi:   state_d = StLdLo;
      StLdLo:   state_d = StLdDv;
      StLdDv: begin
        state_d = StCalc;
`ifdef DIVZERO_CHK_EN
        if (data_in_i == 5'd0) state_d = StOutQh;
`endif
      end
      StCalc:   if (cnt_q == 4'd9) state_d = StOutQh;
      StOutQh:  state_d = StOutQl;
      StOutQl:  state_d = StOutRem;
      StOutRem: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture and one restoring step per CALC cycle.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
`ifdef DIVZERO_CHK_EN
    divz_d = divz_q;
`endif
    case (state_q)
      StLdHi: dvd_d[9:5] = data_in_i;
      StLdLo: dvd_d[4:0] = data_in_i;
      StLdDv: begin
        dvs_d  = data_in_i;
        r_d    = '0;
        cnt_d  = '0;
        quot_d = '0;
`ifdef DIVZERO_CHK_EN
        divz_d = (data_in_i == 5'd0);
        // Same values the full CALC run would produce for a zero divisor.
        if (data_in_i == 5'd0) begin
          quot_d = 10'h3FF;
          r_d    = dvd_q[4:0];
        end
`endif
      end
      StCalc: begin
        r_d    = r_ge ? r_sub : r_prime[4:0];
        quot_d = {quot_q[8:0], r_ge};
        dvd_d  = {dvd_q[8:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
`ifdef DIVZERO_CHK_EN
      divz_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
`ifdef DIVZERO_CHK_EN
      divz_q  <= divz_d;
`endif
    end
  end

  // Outputs decoded from registered state only; no input-to-output path.
  always_comb begin
    done_o     = 1'b0;
    data_out_o = '0;
`ifdef DIVZERO_CHK_EN
    err_o      = 1'b0;
`endif
    case (state_q)
      StOutQh: begin
        done_o     = 1'b1;
        data_out_o = quot_q[9:5];
`ifdef DIVZERO_CHK_EN
        err_o      = divz_q;
`endif
      end
      StOutQl: begin
        data_out_o = quot_q[4:0];
`ifdef DIVZERO_CHK_EN
        err_o      = divz_q;
`endif
      end
      StOutRem: begin
        data_out_o = r_q;
`ifdef DIVZERO_CHK_EN
        err_o      = divz_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases plus random operands checked
// against plain-arithmetic division. Honours DIVZERO_CHK_EN for the err port and latency.
module tb_restoring_divider;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [4:0] data_in_i;
  logic       done_o;
  logic [4:0] data_out_o;
`ifdef DIVZERO_CHK_EN
  logic       err_o;
`endif

  int tests = 0;
  int fails = 0;

  restoring_divider u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .data_in_i  (data_in_i),
    .done_o     (done_o),
    .data_out_o (data_out_o)
`ifdef DIVZERO_CHK_EN
    ,
    .err_o      (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag, input bit exp);
`ifdef DIVZERO_CHK_EN
    chk(tag, int'(err_o), int'(exp));
`else
    if (exp) chk(tag, 0, 1);
`endif
  endtask

  // Full transaction; poke pulses start during the wait for done.
  task automatic run_op(input logic [9:0] dvd, input logic [4:0] dvs, input int hold,
                        input bit poke, input string tag);
    int   q_exp;
    int   r_exp;
    int   lat_exp;
    int   lat;
    bit   seen;
    bit   zero;
    zero    = (dvs == 5'd0);
    q_exp   = zero ? 1023 : int'(dvd) / int'(dvs);
    r_exp   = zero ? int'(dvd) % 32 : int'(dvd) % int'(dvs);
    lat_exp = 13;
`ifdef DIVZERO_CHK_EN
    if (zero) lat_exp = 3;
`endif
    start_i = 1'b1;
    repeat (hold) tick();
    start_i = 1'b0;
    tick();                       // now in LD_HI
    data_in_i = dvd[9:5];
    tick();
    data_in_i = dvd[4:0];
    tick();
    data_in_i = dvs;
    tick();
    data_in_i = 5'd0;
    lat  = 3;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (done_o) seen = 1'b1;
      else begin
        start_i = poke && (lat == 5);
        tick();
        lat++;
      end
    end
    start_i = 1'b0;
    chk({tag, ".latency"}, lat, lat_exp);
    chk({tag, ".qh"}, int'(data_out_o), q_exp / 32);
    chk_err({tag, ".err_qh"}, zero && lat_exp == 3);
    tick();
    chk({tag, ".done_ql"}, int'(done_o), 0);
    chk({tag, ".ql"}, int'(data_out_o), q_exp % 32);
    tick();
    chk({tag, ".rem"}, int'(data_out_o), r_exp);
    chk_err({tag, ".err_rem"}, zero && lat_exp == 3);
    tick();
    chk({tag, ".idle_out"}, int'(data_out_o) + 32 * int'(done_o), 0);
    chk_err({tag, ".idle_err"}, 1'b0);
    // A start pulse during CALC must not have queued another operation.
    if (poke) begin
      seen = 1'b0;
      repeat (20) begin
        tick();
        if (done_o) seen = 1'b1;
      end
      chk({tag, ".no_restart"}, int'(seen), 0);
    end
  endtask

  // Reset asserted during the 5th CALC cycle of a 1000/7 operation.
  task automatic abort_op();
    bit seen;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    data_in_i = 5'd31;
    tick();
    data_in_i = 5'd8;
    tick();
    data_in_i = 5'd7;
    tick();                       // 1st CALC cycle
    data_in_i = 5'd0;
    repeat (4) tick();            // 5th CALC cycle
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort.out", int'(data_out_o) + 32 * int'(done_o), 0);
    seen = 1'b0;
    repeat (20) begin
      if (done_o) seen = 1'b1;
      tick();
    end
    chk("abort.no_done", int'(seen), 0);
  endtask

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    data_in_i = 5'd0;
    tick();
    tick();
    chk("reset.done", int'(done_o), 0);
    chk("reset.data_out", int'(data_out_o), 0);
    chk_err("reset.err", 1'b0);
    rst_i = 1'b0;
    tick();
    chk("idle.done", int'(done_o), 0);

    run_op(10'd1000, 5'd7, 1, 1'b0, "d1000_7");
    run_op(10'd1023, 5'd1, 1, 1'b0, "d1023_1");
    run_op(10'd17, 5'd31, 1, 1'b0, "d17_31");
    run_op(10'd1000, 5'd7, 3, 1'b0, "hold3");
    run_op(10'd545, 5'd0, 1, 1'b0, "d545_0");
    abort_op();
    run_op(10'd1000, 5'd7, 1, 1'b0, "after_abort");
    run_op(10'd1000, 5'd7, 1, 1'b1, "poke");
    run_op(10'd0, 5'd5, 1, 1'b0, "d0_5");
    run_op(10'd31, 5'd31, 1, 1'b0, "d31_31");

    for (int i = 0; i < 30; i++) begin
      logic [9:0] a;
      logic [4:0] b;
      a = 10'($urandom_range(0, 1023));
      b = 5'($urandom_range(0, 31));
      run_op(a, b, int'($urandom_range(1, 3)), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
